// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared register-file widths and the write-back queue entry type
package wb_pkg;

    localparam int REG_ID_W   = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ID_W-1:0]   id;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hardwired, so a result aimed at it occupies a slot but never writes.
    function automatic wb_entry_t make_entry(logic [REG_ID_W-1:0] id, logic [REG_DATA_W-1:0] data);
        wb_entry_t e;
        e.live = (id != '0);
        e.id   = id;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular buffer of pending MDU results with kill-by-register-id
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  wb_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ID_W-1:0]   kill_id_i,
    output wb_entry_t             head_o,
    output logic [PTR_W:0]        count_o,
    output logic [PTR_W-1:0]      rd_ptr_o,
    output wb_entry_t [DEPTH-1:0] entries_o
);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && (count_q != (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Unoccupied slots always carry live=0, so consumers may scan the whole array.
    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].id == kill_id_i) begin
                    entries_d[i].live = 1'b0;
                end
            end
        end
        if (do_pop) begin
            entries_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            entries_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            entries_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head_o    = entries_q[rd_ptr_q];
    assign count_o   = count_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = entries_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - register-file write-port sequencer; WB_FORWARD_EN adds queue forwarding ports
module reg_writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ID_W   = REG_ID_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              Clock,
    input  logic              NReset,
    input  logic              AluValid,
    input  logic [ID_W-1:0]   AluRegID,
    input  logic [DATA_W-1:0] AluData,
    input  logic              MduValid,
    output logic              MduReady,
    input  logic [ID_W-1:0]   MduRegID,
    input  logic [DATA_W-1:0] MduData,
    output logic              WbEnable,
    output logic [ID_W-1:0]   WbRegID,
    output logic [DATA_W-1:0] WbData,
`ifdef WB_FORWARD_EN
    input  logic [ID_W-1:0]   FwdRegID,
    output logic              FwdHit,
    output logic [DATA_W-1:0] FwdData,
`endif
    output logic [31:0]       PendingMask
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W:0]        count;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  alu_wr;
    logic                  push;
    logic                  pop;

    logic                  wb_enable_q, wb_enable_d;
    logic [ID_W-1:0]       wb_reg_id_q, wb_reg_id_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;

    assign MduReady = NReset && (count != (PTR_W+1)'(DEPTH));
    assign alu_wr   = AluValid && (AluRegID != '0);
    assign push     = MduValid && MduReady;
    assign pop      = !alu_wr && (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (Clock),
        .rst_ni       (NReset),
        .push_i       (push),
        .push_entry_i (make_entry(MduRegID, MduData)),
        .pop_i        (pop),
        .kill_i       (alu_wr),
        .kill_id_i    (AluRegID),
        .head_o       (head),
        .count_o      (count),
        .rd_ptr_o     (rd_ptr),
        .entries_o    (entries)
    );

    // ALU results win the port; a queued MDU result waits until the ALU is idle or writes r0.
    always_comb begin
        wb_enable_d = 1'b0;
        wb_reg_id_d = wb_reg_id_q;
        wb_data_d   = wb_data_q;
        if (alu_wr) begin
            wb_enable_d = 1'b1;
            wb_reg_id_d = AluRegID;
            wb_data_d   = AluData;
        end else if (pop) begin
            wb_enable_d = head.live && (head.id != '0);
            wb_reg_id_d = head.id;
            wb_data_d   = head.data;
        end
    end

    always_ff @(posedge Clock) begin
        if (!NReset) begin
            wb_enable_q <= 1'b0;
            wb_reg_id_q <= '0;
            wb_data_q   <= '0;
        end else begin
            wb_enable_q <= wb_enable_d;
            wb_reg_id_q <= wb_reg_id_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign WbEnable = wb_enable_q;
    assign WbRegID  = wb_reg_id_q;
    assign WbData   = wb_data_q;

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].live) begin
                PendingMask[entries[i].id] = 1'b1;
            end
        end
        PendingMask[0] = 1'b0;
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        FwdHit  = 1'b0;
        FwdData = '0;
        fwd_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if (entries[fwd_idx].live && (entries[fwd_idx].id == FwdRegID) && (FwdRegID != '0)) begin
                FwdHit  = 1'b1;
                FwdData = entries[fwd_idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed and randomized checks of reg_writeback_queue against a queue model
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        NReset;
    logic        AluValid;
    logic [4:0]  AluRegID;
    logic [31:0] AluData;
    logic        MduValid;
    logic        MduReady;
    logic [4:0]  MduRegID;
    logic [31:0] MduData;
    logic        WbEnable;
    logic [4:0]  WbRegID;
    logic [31:0] WbData;
    logic [31:0] PendingMask;
`ifdef WB_FORWARD_EN
    logic [4:0]  FwdRegID = 5'd0;
    logic        FwdHit;
    logic [31:0] FwdData;
`endif

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .NReset      (NReset),
        .AluValid    (AluValid),
        .AluRegID    (AluRegID),
        .AluData     (AluData),
        .MduValid    (MduValid),
        .MduReady    (MduReady),
        .MduRegID    (MduRegID),
        .MduData     (MduData),
        .WbEnable    (WbEnable),
        .WbRegID     (WbRegID),
        .WbData      (WbData),
`ifdef WB_FORWARD_EN
        .FwdRegID    (FwdRegID),
        .FwdHit      (FwdHit),
        .FwdData     (FwdData),
`endif
        .PendingMask (PendingMask)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          live;
        logic [4:0]  id;
        logic [31:0] data;
    } m_t;

    m_t          mq[$];
    logic        exp_en   = 1'b0;
    logic [4:0]  exp_id   = '0;
    logic [31:0] exp_data = '0;
    int          passes   = 0;
    int          total    = 0;
    bit          armed    = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].id] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic set_in(bit nr, bit av, int aid, logic [31:0] ad, bit mv, int mid, logic [31:0] md);
        NReset   = nr;
        AluValid = av;
        AluRegID = aid[4:0];
        AluData  = ad;
        MduValid = mv;
        MduRegID = mid[4:0];
        MduData  = md;
    endtask

    // One clock: check combinational outputs against the model, advance the model, check registered outputs.
    task automatic cycle();
        bit rdy;
        m_t h;
        #1;
        rdy = NReset && (mq.size() != DEPTH);
        chk("mdu_ready", MduReady, rdy);
        if (armed) chk("pending_mask", PendingMask, model_mask());
`ifdef WB_FORWARD_EN
        if (armed) begin
            bit          hit = 0;
            logic [31:0] fd  = '0;
            if (FwdRegID != 0) foreach (mq[i]) if (mq[i].live && mq[i].id == FwdRegID) begin
                hit = 1;
                fd  = mq[i].data;
            end
            chk("fwd_hit", FwdHit, hit);
            chk("fwd_data", FwdData, fd);
        end
`endif
        @(posedge Clock);
        if (!NReset) begin
            mq.delete();
            exp_en = 0; exp_id = '0; exp_data = '0;
        end else begin
            if (AluValid && AluRegID != 0) begin
                foreach (mq[i]) if (mq[i].id == AluRegID) mq[i].live = 0;
                exp_en = 1; exp_id = AluRegID; exp_data = AluData;
            end else if (mq.size() != 0) begin
                h = mq.pop_front();
                exp_en = h.live && h.id != 0; exp_id = h.id; exp_data = h.data;
            end else begin
                exp_en = 0;
            end
            if (MduValid && rdy) mq.push_back('{live: MduRegID != 0, id: MduRegID, data: MduData});
        end
        armed = 1;
        #1;
        chk("wb_enable", WbEnable, exp_en);
        chk("wb_reg_id", WbRegID, exp_id);
        chk("wb_data", WbData, exp_data);
    endtask

    initial begin
        // Reset held two cycles with the ALU active.
        set_in(0, 1, 5, 32'h1234, 1, 3, 32'h55);
        cycle();
        cycle();
        chk("reset_en", WbEnable, 1'b0);
        chk("reset_data", WbData, 32'h0);
        chk("reset_mask", PendingMask, 32'h0);

        // ALU only.
        set_in(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        chk("alu_data", WbData, 32'hDEADBEEF);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("alu_en_drop", WbEnable, 1'b0);

        // Fill with the ALU busy on r31 so nothing pops, then drain.
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 1, 31, 32'(i * 100), 1, i, 32'hA0 + 32'(i));
            cycle();
        end
        chk("full_mask", PendingMask, 32'h1E);
        chk("full_ready", MduReady, 1'b0);
        set_in(1, 1, 31, 32'h0, 1, 6, 32'hFF);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("drain_first_id", WbRegID, 32'd1);
        chk("drain_mask", PendingMask, 32'h1C);
        repeat (4) cycle();

        // Kill: queued r7 overwritten by a later ALU write.
        set_in(1, 0, 0, 0, 1, 7, 32'h11);
        cycle();
        set_in(1, 1, 7, 32'h22, 0, 0, 0);
        cycle();
        chk("kill_mask7", PendingMask[7], 1'b0);
        chk("kill_alu_data", WbData, 32'h22);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("kill_pop_en", WbEnable, 1'b0);

        // Same-cycle push and ALU write to r9: ALU first, queued value after.
        set_in(1, 1, 9, 32'hB, 1, 9, 32'hA);
        cycle();
        chk("same_first", WbData, 32'hB);
        chk("same_mask9", PendingMask[9], 1'b1);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("same_second", WbData, 32'hA);
        chk("same_en", WbEnable, 1'b1);

`ifdef WB_FORWARD_EN
        set_in(1, 1, 31, 0, 1, 3, 32'h1);
        cycle();
        set_in(1, 1, 31, 0, 1, 3, 32'h2);
        cycle();
        FwdRegID = 5'd3;
        #1;
        chk("fwd3_hit", FwdHit, 1'b1);
        chk("fwd3_data", FwdData, 32'h2);
        FwdRegID = 5'd0;
        #1;
        chk("fwd0_hit", FwdHit, 1'b0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
`endif

        // Randomized traffic on a narrow register range to force collisions.
        repeat (500) begin
            set_in(($urandom % 40) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom);
`ifdef WB_FORWARD_EN
            FwdRegID = 5'($urandom_range(0, 7));
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
